// File: rtl/sa_skew_loader.sv
// Buffers one DEPTH x NUM_LANE tile streamed in row-major order and writes it
// out as DEPTH+NUM_LANE-1 diagonally skewed wavefront words for a systolic input bank.
module sa_skew_loader #(
    parameter int NUM_LANE             = 16,
    parameter int DEPTH                = 16,
    parameter int DATA_WIDTH           = 16,
    parameter int LOG2_SRAM_BANK_DEPTH = 9
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0]  i_base_addr,
    input  logic                             i_valid,
    input  logic [DATA_WIDTH-1:0]            i_data,
    output logic                             o_ready,
    output logic                             o_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]  o_wr_addr,
    output logic [NUM_LANE*DATA_WIDTH-1:0]   o_wr_data,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int NUM_WORD = DEPTH + NUM_LANE - 1;
    localparam int ROW_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COL_W    = (NUM_LANE > 1) ? $clog2(NUM_LANE) : 1;
    localparam int M_W      = $clog2(NUM_WORD + 1);
    localparam int AW       = LOG2_SRAM_BANK_DEPTH;
    localparam int WW       = NUM_LANE * DATA_WIDTH;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DEPTH - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_LANE - 1);
    localparam logic [M_W-1:0]   LAST_M   = M_W'(NUM_WORD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [AW-1:0]           r_base;
    logic [ROW_W-1:0]        r_row;
    logic [COL_W-1:0]        r_col;
    logic [M_W-1:0]          r_m;
    logic [M_W-1:0]          w_m_next;
    logic                    w_accept;
    logic                    w_last_elem;
    logic                    w_emit_next;
    logic [WW-1:0]           w_word;

    logic                    r_wr_en;
    logic [AW-1:0]           r_wr_addr;
    logic [WW-1:0]           r_wr_data;
    logic                    r_done;

    logic [DATA_WIDTH-1:0]   r_tile [DEPTH][NUM_LANE];

    assign w_accept    = (r_state == ST_FILL) && i_valid;
    assign w_last_elem = (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_emit_next = (w_next_state == ST_EMIT);

    // Index of the word to be registered at the coming edge: word 0 is
    // launched on the edge that accepts the last element.
    assign w_m_next = (r_state == ST_EMIT) ? r_m + 1'b1 : '0;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_start)                 w_next_state = ST_FILL;
            ST_FILL: if (w_accept && w_last_elem) w_next_state = ST_EMIT;
            ST_EMIT: if (r_m == LAST_M)           w_next_state = ST_DONE;
            ST_DONE:                              w_next_state = ST_IDLE;
            default:                              w_next_state = ST_IDLE;
        endcase
    end

    // Lane j of word m is T[m-j][j]; outside the tile it is a padding zero.
    // Word 0 needs only T[0][0], which is already stored when it is launched.
    always_comb begin
        w_word = '0;
        for (int j = 0; j < NUM_LANE; j++) begin
            if ((int'(w_m_next) >= j) && (int'(w_m_next) - j < DEPTH)) begin
                w_word[j*DATA_WIDTH +: DATA_WIDTH] = r_tile[ROW_W'(int'(w_m_next) - j)][j];
            end
        end
    end

    // NOTE: the tile buffer has no reset; every entry is rewritten during FILL
    // before EMIT reads it, so clearing it would only cost a reset fan-out.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tile[r_row][r_col] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_base    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_m       <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if ((r_state == ST_IDLE) && i_start) begin
                r_base <= i_base_addr;
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_accept) begin
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            r_m       <= w_emit_next ? w_m_next : '0;
            r_wr_en   <= w_emit_next;
            r_wr_addr <= w_emit_next ? r_base + AW'(w_m_next) : '0;
            r_wr_data <= w_emit_next ? w_word : '0;
            r_done    <= (w_next_state == ST_DONE);
        end
    end

    assign o_ready   = (r_state == ST_FILL);
    assign o_busy    = (r_state == ST_FILL) || (r_state == ST_EMIT);
    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_done    = r_done;

endmodule

// File: tb/tb_sa_skew_loader.sv
// Self-checking bench for sa_skew_loader (4x4 tile): a reference model pushes
// expected SRAM writes to a queue, a monitor pops and compares each write.
module tb_sa_skew_loader;

    localparam int NL = 4;
    localparam int D  = 4;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int NW = NL + D - 1;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [NL*DW-1:0] data;
    } wr_t;

    logic             clk;
    logic             rst_n;
    logic             i_start;
    logic [AW-1:0]    i_base_addr;
    logic             i_valid;
    logic [DW-1:0]    i_data;
    logic             o_ready;
    logic             o_wr_en;
    logic [AW-1:0]    o_wr_addr;
    logic [NL*DW-1:0] o_wr_data;
    logic             o_busy;
    logic             o_done;

    wr_t  exp_q[$];
    wr_t  got_log[$];
    int   got_cyc[$];
    int   done_cycs[$];
    int   cyc;
    int   last_accept;
    int   n_checks;
    int   n_errors;

    sa_skew_loader #(
        .NUM_LANE(NL),
        .DEPTH(D),
        .DATA_WIDTH(DW),
        .LOG2_SRAM_BANK_DEPTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_start(i_start),
        .i_base_addr(i_base_addr),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_ready(o_ready),
        .o_wr_en(o_wr_en),
        .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_wr_en) begin
                wr_t g;
                wr_t e;
                g.addr = o_wr_addr;
                g.data = o_wr_data;
                got_log.push_back(g);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'(o_wr_addr), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(o_wr_addr), 64'(e.addr));
                    check("wr_data", o_wr_data, e.data);
                end
            end
            if (o_done) begin
                done_cycs.push_back(cyc);
                check("busy_at_done", 64'(o_busy), 64'd0);
            end
        end
    end

    task automatic clear_logs();
        exp_q.delete();
        got_log.delete();
        got_cyc.delete();
        done_cycs.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 64'(o_ready), 64'd0);
        check({tag, "_wr_en"}, 64'(o_wr_en), 64'd0);
        check({tag, "_wr_addr"}, 64'(o_wr_addr), 64'd0);
        check({tag, "_wr_data"}, o_wr_data, 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_done"}, 64'(o_done), 64'd0);
    endtask

    // Build the tile, push its expected skewed words, then start and stream it.
    task automatic load_tile(input logic [AW-1:0] base, input bit ones, input bit stall, input bit poke);
        logic [DW-1:0] tile_v [NL*D];
        int k;
        int t;
        logic rdy;
        for (int i = 0; i < NL*D; i++) tile_v[i] = ones ? 16'hFFFF : DW'(i + 1);
        for (int m = 0; m < NW; m++) begin
            wr_t e;
            e.addr = base + AW'(m);
            e.data = '0;
            for (int j = 0; j < NL; j++) begin
                if ((m - j >= 0) && (m - j < D)) e.data[j*DW +: DW] = tile_v[(m-j)*NL + j];
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        i_start     = 1'b1;
        i_base_addr = base;
        i_valid     = 1'b1;
        i_data      = 16'hDEAD;
        @(negedge clk);
        i_start     = 1'b0;
        i_base_addr = '0;
        check("ready_after_start", 64'(o_ready), 64'd1);
        k = 0;
        t = 0;
        while (k < NL*D && t < 200) begin
            i_valid = stall ? (t % 2 == 0) : 1'b1;
            i_data  = tile_v[k];
            i_start = poke && (k == 5);
            rdy     = o_ready;
            if (i_valid && rdy) begin
                k++;
                last_accept = cyc + 1;
            end
            t++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_data  = '0;
        i_start = poke;
        if (k < NL*D) check("fill_timeout", 64'(k), 64'(NL*D));
        if (poke) begin
            @(negedge clk);
            i_start = 1'b0;
        end
    endtask

    task automatic wait_done(input int n);
        int t;
        t = 0;
        while (done_cycs.size() < n && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (done_cycs.size() < n) check("done_timeout", 64'(done_cycs.size()), 64'(n));
    endtask

    // Count, contiguity and latency checks for a single completed tile.
    task automatic check_run(input string tag);
        check({tag, "_n_writes"}, 64'(got_log.size()), 64'(NW));
        check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_n_done"}, 64'(done_cycs.size()), 64'd1);
        if (got_cyc.size() == NW) begin
            check({tag, "_first_wr_cyc"}, 64'(got_cyc[0]), 64'(last_accept));
            check({tag, "_contiguous"}, 64'(got_cyc[NW-1] - got_cyc[0]), 64'(NW - 1));
            if (done_cycs.size() > 0)
                check({tag, "_done_cyc"}, 64'(done_cycs[0]), 64'(got_cyc[NW-1] + 1));
        end
    endtask

    initial begin
        int t;
        n_checks    = 0;
        n_errors    = 0;
        last_accept = 0;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_valid     = 1'b0;
        i_data      = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic skew, base 1; start with i_valid high must not accept an element.
        clear_logs();
        load_tile(9'd1, 1'b0, 1'b0, 1'b0);
        wait_done(1);
        repeat (5) @(negedge clk);
        check_run("basic");
        if (got_log.size() == NW) begin
            check("basic_w0", got_log[0].data, 64'h0000_0000_0000_0001);
            check("basic_w3", got_log[3].data, 64'h0004_0007_000A_000D);
            check("basic_w6", got_log[6].data, 64'h0010_0000_0000_0000);
            check("basic_a0", 64'(got_log[0].addr), 64'd1);
            check("basic_a6", 64'(got_log[6].addr), 64'd7);
        end

        // Input stalls: i_valid toggles 1,0,1,0.
        clear_logs();
        load_tile(9'd1, 1'b0, 1'b1, 1'b0);
        wait_done(1);
        repeat (5) @(negedge clk);
        check_run("stall");

        // Address wrap at the top of the bank.
        clear_logs();
        load_tile(9'd510, 1'b0, 1'b0, 1'b0);
        wait_done(1);
        repeat (5) @(negedge clk);
        check_run("wrap");
        if (got_log.size() == NW) begin
            check("wrap_a1", 64'(got_log[1].addr), 64'd511);
            check("wrap_a2", 64'(got_log[2].addr), 64'd0);
            check("wrap_a6", 64'(got_log[6].addr), 64'd4);
        end

        // i_start pulsed during FILL and EMIT is ignored.
        clear_logs();
        load_tile(9'd1, 1'b0, 1'b0, 1'b1);
        wait_done(1);
        repeat (10) @(negedge clk);
        check_run("poke");
        check("poke_idle_busy", 64'(o_busy), 64'd0);
        check("poke_idle_ready", 64'(o_ready), 64'd0);

        // Reset after the third write: outputs clear at once, nothing else follows.
        clear_logs();
        load_tile(9'd1, 1'b0, 1'b0, 1'b0);
        t = 0;
        while (got_log.size() < 3 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("rst_saw_3_writes", 64'(got_log.size()), 64'd3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_emit_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_no_more_writes", 64'(got_log.size()), 64'd3);
        check("rst_no_done", 64'(done_cycs.size()), 64'd0);
        check("rst_idle_busy", 64'(o_busy), 64'd0);
        clear_logs();
        load_tile(9'd1, 1'b0, 1'b0, 1'b0);
        wait_done(1);
        repeat (5) @(negedge clk);
        check_run("after_reset");

        // Back-to-back tiles, the second started the cycle after o_done.
        clear_logs();
        load_tile(9'd0, 1'b0, 1'b0, 1'b0);
        wait_done(1);
        load_tile(9'd7, 1'b1, 1'b0, 1'b0);
        wait_done(2);
        repeat (5) @(negedge clk);
        check("b2b_n_writes", 64'(got_log.size()), 64'(2*NW));
        check("b2b_n_done", 64'(done_cycs.size()), 64'd2);
        check("b2b_sb_empty", 64'(exp_q.size()), 64'd0);
        if (got_log.size() == 2*NW) begin
            check("b2b_t2_w0", got_log[NW].data, 64'h0000_0000_0000_FFFF);
            check("b2b_t2_a0", 64'(got_log[NW].addr), 64'd7);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
